// File: rtl/window_fp_pkg.sv
// Shared constants and the exact unsigned-integer to fp32 converter for the 7x7 window feeder.
package window_fp_pkg;

   localparam int unsigned KSIZE  = 7;
   localparam int unsigned FP_W   = 32;
   localparam int unsigned LINE_W = KSIZE * FP_W;
   localparam int unsigned CONV_W = 24;

   // Exact for any input up to 24 bits: the whole value fits in the 24-bit significand.
   function automatic logic [FP_W-1:0] u2fp32(input logic [CONV_W-1:0] v);
      logic [CONV_W-1:0] sh;
      logic [FP_W-1:0]   r;
      int                msb;
      msb = 0;
      sh  = '0;
      r   = '0;
      for (int i = 0; i < int'(CONV_W); i++) begin
         if (v[i]) msb = i;
      end
      if (v != '0) begin
         sh = v << (int'(CONV_W) - 1 - msb);
         r  = {1'b0, 8'(127 + msb), sh[CONV_W-2:0]};
      end
      return r;
   endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One image row of pixels; combinational read and registered write at the same address (read-before-write).
module line_buffer_ram #(
   parameter int unsigned DEPTH = 28,
   parameter int unsigned W     = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata_c
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata_c = mem[addr];

endmodule

// File: rtl/window_7x7_fp.sv
// Sliding 7x7 window over a raster pixel stream, emitted as seven rows of fp32 values.
module window_7x7_fp
   import window_fp_pkg::*;
#(
   parameter int unsigned IMG_W = 28,
   parameter int unsigned IMG_H = 28,
   parameter int unsigned PIX_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              de_in,
   input  logic [PIX_W-1:0]  pixel_in,
   output logic              de_out,
   output logic [LINE_W-1:0] line_0_out,
   output logic [LINE_W-1:0] line_1_out,
   output logic [LINE_W-1:0] line_2_out,
   output logic [LINE_W-1:0] line_3_out,
   output logic [LINE_W-1:0] line_4_out,
   output logic [LINE_W-1:0] line_5_out,
   output logic [LINE_W-1:0] line_6_out
);

   localparam int unsigned XW   = $clog2(IMG_W);
   localparam int unsigned YW   = $clog2(IMG_H);
   localparam int unsigned NROW = KSIZE - 1;

   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic              v1;
   logic              accept_c;
   logic [PIX_W-1:0]  lb_rd  [NROW];
   logic [PIX_W-1:0]  col_c  [KSIZE];
   logic [PIX_W-1:0]  win    [KSIZE][KSIZE];
   logic [LINE_W-1:0] fp_c   [KSIZE];
   logic [LINE_W-1:0] line_q [KSIZE];

   assign accept_c = de_in & ~reset;

   // Each buffer takes the row below it, so lb0 always holds the oldest row.
   for (genvar i = 0; i < int'(NROW); i++) begin : g_lb
      logic [PIX_W-1:0] wdata;
      if (i == int'(NROW) - 1) begin : g_top
         assign wdata = pixel_in;
      end else begin : g_mid
         assign wdata = lb_rd[i+1];
      end
      line_buffer_ram #(
         .DEPTH (IMG_W),
         .W     (PIX_W),
         .AW    (XW)
      ) u_lb (
         .clk     (clk),
         .we      (accept_c),
         .addr    (x),
         .wdata   (wdata),
         .rdata_c (lb_rd[i])
      );
   end

   always_comb begin
      for (int r = 0; r < int'(NROW); r++) col_c[r] = lb_rd[r];
      col_c[KSIZE-1] = pixel_in;
   end

   // Raster position and the stage-1 window-valid flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         x  <= '0;
         y  <= '0;
         v1 <= 1'b0;
      end else begin
         v1 <= de_in && (x >= XW'(KSIZE-1)) && (y >= YW'(KSIZE-1));
         if (de_in) begin
            if (x == XW'(IMG_W-1)) begin
               x <= '0;
               y <= (y == YW'(IMG_H-1)) ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < int'(KSIZE); r++)
            for (int c = 0; c < int'(KSIZE); c++)
               win[r][c] <= '0;
      end else if (de_in) begin
         for (int r = 0; r < int'(KSIZE); r++) begin
            for (int c = 0; c < int'(KSIZE) - 1; c++) win[r][c] <= win[r][c+1];
            win[r][KSIZE-1] <= col_c[r];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < int'(KSIZE); r++) begin
         fp_c[r] = '0;
         for (int c = 0; c < int'(KSIZE); c++)
            fp_c[r][(int'(KSIZE)-1-c)*int'(FP_W) +: FP_W] = u2fp32(CONV_W'(win[r][c]));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         de_out <= 1'b0;
         for (int r = 0; r < int'(KSIZE); r++) line_q[r] <= '0;
      end else begin
         de_out <= v1;
         if (v1) begin
            for (int r = 0; r < int'(KSIZE); r++) line_q[r] <= fp_c[r];
         end
      end
   end

   assign line_0_out = line_q[0];
   assign line_1_out = line_q[1];
   assign line_2_out = line_q[2];
   assign line_3_out = line_q[3];
   assign line_4_out = line_q[4];
   assign line_5_out = line_q[5];
   assign line_6_out = line_q[6];

endmodule

// File: tb/tb_window_7x7_fp.sv
// Directed bench for window_7x7_fp on a 10x10 image: frame-memory model plus hand-computed windows.
module tb_window_7x7_fp;
   import window_fp_pkg::*;

   localparam int unsigned IW = 10;
   localparam int unsigned IH = 10;
   localparam int unsigned PW = 8;

   typedef logic [KSIZE-1:0][LINE_W-1:0] win_t;
   typedef struct {
      int   cyc;
      win_t lines;
   } wrec_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              de_in;
   logic [PW-1:0]     pixel_in;
   logic              de_out;
   logic [LINE_W-1:0] l0, l1, l2, l3, l4, l5, l6;
   win_t              dut_lines;

   wrec_t         exp_q[$];
   wrec_t         log_q[$];
   win_t          ref_w [16];
   logic [PW-1:0] mimg [IH][IW];
   int            n_chk = 0;
   int            n_bad = 0;
   int            cyc = 0;
   int            mx, my, c_last, c67;
   bit            mon_on = 0;
   bit            alt_on = 0;

   always #5 clk = ~clk;

   assign dut_lines = {l6, l5, l4, l3, l2, l1, l0};

   window_7x7_fp #(.IMG_W(IW), .IMG_H(IH), .PIX_W(PW)) dut (
      .clk        (clk),
      .reset      (reset),
      .de_in      (de_in),
      .pixel_in   (pixel_in),
      .de_out     (de_out),
      .line_0_out (l0),
      .line_1_out (l1),
      .line_2_out (l2),
      .line_3_out (l3),
      .line_4_out (l4),
      .line_5_out (l5),
      .line_6_out (l6)
   );

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] expv);
      n_chk++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, expv);
      end
   endtask

   function automatic logic [PW-1:0] pat(input int k, input int x, input int y);
      logic [PW-1:0] cv [5];
      cv = '{8'd0, 8'd1, 8'd7, 8'd128, 8'd255};
      case (k)
         0:       return 8'(x + y);
         1:       return 8'(255 - (x + y));
         default: return cv[x % 5];
      endcase
   endfunction

   function automatic win_t model_win();
      win_t w;
      w = '0;
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 7; c++)
            w[r][(6-c)*32 +: 32] = u2fp32(CONV_W'(mimg[my-6+r][mx-6+c]));
      return w;
   endfunction

   function automatic win_t log_win(input int i);
      if (i < log_q.size()) return log_q[i].lines;
      return '0;
   endfunction

   function automatic int log_cyc(input int i);
      if (i < log_q.size()) return log_q[i].cyc;
      return -1;
   endfunction

   task automatic drive(input bit de, input logic [PW-1:0] p);
      wrec_t e;
      @(negedge clk);
      de_in    = de;
      pixel_in = p;
      c_last   = cyc;
      if (de) begin
         mimg[my][mx] = p;
         if (mx >= 6 && my >= 6) begin
            e.cyc   = cyc + 2;
            e.lines = model_win();
            exp_q.push_back(e);
         end
         if (mx == IW - 1) begin
            mx = 0;
            my = (my == IH - 1) ? 0 : my + 1;
         end else begin
            mx++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 8'h00);
   endtask

   // gap: 0 none, 1 random bursts, 2 strict alternation
   task automatic run_frame(input int k, input int gap);
      for (int y = 0; y < int'(IH); y++) begin
         for (int x = 0; x < int'(IW); x++) begin
            if (gap == 1)
               for (int g = 0; g < 3 && $urandom_range(1) == 1; g++) drive(1'b0, 8'hAA);
            drive(1'b1, pat(k, x, y));
            if (x == 6 && y == 6) c67 = c_last;
            if (gap == 2) drive(1'b0, 8'h55);
         end
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_de"}, LINE_W'(de_out), '0);
      for (int r = 0; r < 7; r++) chk($sformatf("%s_line%0d", tag, r), dut_lines[r], '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      win_t w;
      bit   stop;
      reset    = 1'b1;
      de_in    = 1'b0;
      pixel_in = '0;
      mx       = 0;
      my       = 0;
      c67      = 0;

      fork
         forever begin
            @(posedge clk);
            cyc++;
         end
         begin : monitor
            bit    prev_de;
            bit    exp_de;
            wrec_t e;
            prev_de = 1'b0;
            forever begin
               @(negedge clk);
               if (mon_on) begin
                  exp_de = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
                  chk("de_out", LINE_W'(de_out), LINE_W'(exp_de));
                  if (alt_on) chk("de_b2b", LINE_W'(prev_de & de_out), '0);
                  if (de_out) begin
                     e.cyc   = cyc;
                     e.lines = dut_lines;
                     log_q.push_back(e);
                  end
                  if (exp_de) begin
                     e = exp_q.pop_front();
                     for (int r = 0; r < 7; r++)
                        chk($sformatf("win_line%0d", r), dut_lines[r], e.lines[r]);
                  end
               end
               prev_de = de_out;
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk_reset_state("rst");
      reset  = 1'b0;
      mon_on = 1'b1;

      // A: gap-free ramp image
      log_q.delete();
      run_frame(0, 0);
      idle(4);
      chk("a_count", LINE_W'(log_q.size()), LINE_W'(16));
      chk("a_first_lat", LINE_W'(log_cyc(0)), LINE_W'(c67 + 2));
      w = log_win(0);
      chk("a_line0", w[0], {32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                            32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000});
      chk("a_l6_c0", LINE_W'(w[6][223:192]), LINE_W'(32'h40C0_0000));
      chk("a_l6_c6", LINE_W'(w[6][31:0]), LINE_W'(32'h4140_0000));
      for (int i = 0; i < 16; i++) ref_w[i] = log_win(i);

      // B: same image with random input gaps
      log_q.delete();
      run_frame(0, 1);
      idle(4);
      chk("b_count", LINE_W'(log_q.size()), LINE_W'(16));
      for (int i = 0; i < 16; i++) begin
         w = log_win(i);
         for (int r = 0; r < 7; r++) chk($sformatf("b_same_w%0d_r%0d", i, r), w[r], ref_w[i][r]);
      end

      // C then D: alternating-gap frame followed directly by the inverted frame
      log_q.delete();
      alt_on = 1'b1;
      run_frame(0, 2);
      alt_on = 1'b0;
      run_frame(1, 0);
      idle(4);
      chk("cd_count", LINE_W'(log_q.size()), LINE_W'(32));
      w = log_win(16);
      chk("d_line0", w[0], {32'h437F_0000, 32'h437E_0000, 32'h437D_0000, 32'h437C_0000,
                            32'h437B_0000, 32'h437A_0000, 32'h4379_0000});
      chk("d_l6_c0", LINE_W'(w[6][223:192]), LINE_W'(32'h4379_0000));
      chk("d_l6_c6", LINE_W'(w[6][31:0]), LINE_W'(32'h4373_0000));

      // E: converter corner values
      log_q.delete();
      run_frame(2, 0);
      idle(4);
      w = log_win(0);
      chk("e_corners", w[6], {32'h0000_0000, 32'h3F80_0000, 32'h40E0_0000, 32'h4300_0000,
                              32'h437F_0000, 32'h0000_0000, 32'h3F80_0000});

      // F: one-cycle reset at (4,7) mid-frame
      stop = 1'b0;
      for (int y = 0; y < int'(IH) && !stop; y++) begin
         for (int x = 0; x < int'(IW) && !stop; x++) begin
            if (y == 7 && x == 4) stop = 1'b1;
            else drive(1'b1, pat(0, x, y));
         end
      end
      @(negedge clk);
      reset    = 1'b1;
      de_in    = 1'b1;
      pixel_in = 8'h99;
      exp_q.delete();
      mx = 0;
      my = 0;
      @(negedge clk);
      reset = 1'b0;
      de_in = 1'b0;
      chk_reset_state("f_rst");
      log_q.delete();
      run_frame(0, 0);
      idle(4);
      chk("f_count", LINE_W'(log_q.size()), LINE_W'(16));
      chk("f_first_lat", LINE_W'(log_cyc(0)), LINE_W'(c67 + 2));
      w = log_win(0);
      chk("f_line0", w[0], ref_w[0][0]);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
